// File: rtl/axis_gap_arbiter.sv
// Round-robin, packet-locked AXIS arbiter. After each packet it holds the link
// idle for a programmable number of cycles before it issues the next grant.
module axis_gap_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int GAP_WIDTH  = 9
) (
    input  logic                            clk,
    input  logic                            reset_,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    output logic [NUM_PORTS-1:0]            s_tready,
    output logic                            m_tvalid,
    output logic                            m_tlast,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    input  logic                            m_tready,
    input  logic                            enable,
    input  logic [NUM_PORTS-1:0]            port_mask,
    input  logic [GAP_WIDTH-1:0]            gap,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            gap_active,
    output logic                            busy,
    output logic [1:0]                      state_dbg
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       last_ptr;
    logic [GAP_WIDTH-1:0]   gap_cnt;

    logic [NUM_PORTS-1:0]   req;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic                   last_beat;

    // Search upward from the port after the last owner; first requester wins.
    always_comb begin
        int cand;
        req        = s_tvalid & port_mask;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = int'(last_ptr) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!pick_valid && req[IDX_W'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Handshake: a beat transfers on any cycle where valid and ready are both
    // high; valid is never withdrawn by this block, and ready is routed only
    // to the owner, so no other source can see a transfer complete.
    always_comb begin
        s_tready = grant & {NUM_PORTS{m_tready}};
        m_tvalid = |(grant & s_tvalid);
        m_tlast  = |(grant & s_tlast);
        m_tdata  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                m_tdata = m_tdata | s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign last_beat = m_tvalid & m_tready & m_tlast;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_ptr   <= IDX_W'(NUM_PORTS - 1);
            gap_cnt    <= '0;
            busy       <= 1'b0;
            gap_active <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && pick_valid) begin
                        state    <= ST_XFER;
                        grant    <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_idx;
                        last_ptr <= pick_idx;
                        busy     <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (last_beat) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        if (gap == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            state      <= ST_GAP;
                            gap_cnt    <= gap;
                            gap_active <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    // The count was captured on the tlast beat; gap is not re-read.
                    gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    if (gap_cnt == GAP_WIDTH'(1)) begin
                        state      <= ST_IDLE;
                        gap_active <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    grant      <= '0;
                    busy       <= 1'b0;
                    gap_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_gap_arbiter.sv
// Directed cycle-by-cycle vectors for axis_gap_arbiter, with a data scoreboard
// that tracks the order of every accepted output beat.
module tb_axis_gap_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int GW = 9;

    logic            clk;
    logic            reset_;
    logic [NP-1:0]   s_tvalid;
    logic [NP-1:0]   s_tlast;
    logic [NP*DW-1:0] s_tdata;
    logic [NP-1:0]   s_tready;
    logic            m_tvalid;
    logic            m_tlast;
    logic [DW-1:0]   m_tdata;
    logic            m_tready;
    logic            enable;
    logic [NP-1:0]   port_mask;
    logic [GW-1:0]   gap;
    logic [NP-1:0]   grant;
    logic            gap_active;
    logic            busy;
    logic [1:0]      state_dbg;

    axis_gap_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .GAP_WIDTH(GW)) dut (
        .clk        (clk),
        .reset_     (reset_),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tdata    (s_tdata),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tdata    (m_tdata),
        .m_tready   (m_tready),
        .enable     (enable),
        .port_mask  (port_mask),
        .gap        (gap),
        .grant      (grant),
        .gap_active (gap_active),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          rst_n;
        logic [NP-1:0] sv;
        logic [NP-1:0] sl;
        logic          tr;
        logic          en;
        logic [NP-1:0] mask;
        logic [GW-1:0] gp;
        logic [NP-1:0] eg;
        logic          emv;
        logic          eml;
        logic [NP-1:0] esr;
        logic          ega;
        logic          eb;
    } vec_t;

    vec_t           vecs[$];
    logic [DW-1:0]  exp_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;

    task automatic add(input string name, input logic rst_n,
                       input logic [NP-1:0] sv, input logic [NP-1:0] sl,
                       input logic tr, input logic en, input logic [NP-1:0] mask,
                       input logic [GW-1:0] gp, input logic [NP-1:0] eg,
                       input logic emv, input logic eml, input logic [NP-1:0] esr,
                       input logic ega, input logic eb);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.sv = sv; v.sl = sl; v.tr = tr;
        v.en = en; v.mask = mask; v.gp = gp; v.eg = eg; v.emv = emv;
        v.eml = eml; v.esr = esr; v.ega = ega; v.eb = eb;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int k, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %0h expected %0h", name, k, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NP-1:0] oh);
        int idx = 0;
        for (int i = 0; i < NP; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

    task automatic build_table();
        int t1_order[5] = '{0, 1, 2, 3, 0};
        int t4_order[4] = '{1, 3, 1, 3};
        logic [NP-1:0] oh;
        // round robin over all ports, 2-beat packets, no gap
        foreach (t1_order[j]) begin
            oh = 4'b0001 << t1_order[j];
            add("rr_idle",  1, 4'hF, 4'h0, 1, 1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0, 0);
            add("rr_beat0", 1, 4'hF, 4'h0, 1, 1, 4'hF, 0, oh,   1, 0, oh,   0, 1);
            add("rr_beat1", 1, 4'hF, oh,   1, 1, 4'hF, 0, oh,   1, 1, oh,   0, 1);
        end
        // mask 1010 with single-beat packets: ports 1 and 3 alternate
        foreach (t4_order[j]) begin
            oh = 4'b0001 << t4_order[j];
            add("mask_idle", 1, 4'hF, 4'hF, 1, 1, 4'hA, 0, 4'h0, 0, 0, 4'h0, 0, 0);
            add("mask_xfer", 1, 4'hF, 4'hF, 1, 1, 4'hA, 0, oh,   1, 1, oh,   0, 1);
        end
        // port 2 single beats, gap 5 then gap 1
        add("gap_idle", 1, 4'h4, 4'h4, 1, 1, 4'hF, 5, 4'h0, 0, 0, 4'h0, 0, 0);
        add("gap_xfer", 1, 4'h4, 4'h4, 1, 1, 4'hF, 5, 4'h4, 1, 1, 4'h4, 0, 1);
        for (int j = 0; j < 5; j++)
            add("gap5_cnt", 1, 4'h4, 4'h4, 1, 1, 4'hF, 5, 4'h0, 0, 0, 4'h0, 1, 0);
        add("gap5_idle",  1, 4'h4, 4'h4, 1, 1, 4'hF, 5, 4'h0, 0, 0, 4'h0, 0, 0);
        add("gap5_next",  1, 4'h4, 4'h4, 1, 1, 4'hF, 1, 4'h4, 1, 1, 4'h4, 0, 1);
        add("gap1_cnt",   1, 4'h0, 4'h0, 1, 1, 4'hF, 1, 4'h0, 0, 0, 4'h0, 1, 0);
        add("gap1_idle",  1, 4'h0, 4'h0, 1, 1, 4'hF, 1, 4'h0, 0, 0, 4'h0, 0, 0);
        // port 1 with ready toggling and a valid dropout; port 3 kept waiting
        add("lock_idle",  1, 4'h2, 4'h0, 1, 1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0, 0);
        add("lock_nrdy0", 1, 4'hA, 4'h0, 0, 1, 4'hF, 0, 4'h2, 1, 0, 4'h0, 0, 1);
        add("lock_beat0", 1, 4'hA, 4'h0, 1, 1, 4'hF, 0, 4'h2, 1, 0, 4'h2, 0, 1);
        add("lock_stall", 1, 4'h8, 4'h0, 1, 1, 4'hF, 0, 4'h2, 0, 0, 4'h2, 0, 1);
        add("lock_nrdy1", 1, 4'hA, 4'h0, 0, 1, 4'hF, 0, 4'h2, 1, 0, 4'h0, 0, 1);
        add("lock_beat1", 1, 4'hA, 4'h0, 1, 1, 4'hF, 0, 4'h2, 1, 0, 4'h2, 0, 1);
        add("lock_nrdy2", 1, 4'hA, 4'h2, 0, 1, 4'hF, 0, 4'h2, 1, 1, 4'h0, 0, 1);
        add("lock_last",  1, 4'hA, 4'h2, 1, 1, 4'hF, 0, 4'h2, 1, 1, 4'h2, 0, 1);
        add("lock_idle2", 1, 4'h8, 4'h8, 1, 1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0, 0);
        add("lock_p3",    1, 4'h8, 4'h8, 1, 1, 4'hF, 0, 4'h8, 1, 1, 4'h8, 0, 1);
        // enable and mask drop mid-packet on port 0; gap input changes after tlast
        add("en_idle",  1, 4'h1, 4'h0, 1, 1, 4'hF, 5, 4'h0, 0, 0, 4'h0, 0, 0);
        add("en_beat0", 1, 4'h1, 4'h0, 1, 0, 4'hE, 5, 4'h1, 1, 0, 4'h1, 0, 1);
        add("en_last",  1, 4'h1, 4'h1, 1, 0, 4'hE, 5, 4'h1, 1, 1, 4'h1, 0, 1);
        for (int j = 0; j < 5; j++)
            add("en_gap", 1, 4'h1, 4'h1, 1, 0, 4'hF, 2, 4'h0, 0, 0, 4'h0, 1, 0);
        add("en_off0",  1, 4'h1, 4'h1, 1, 0, 4'hF, 2, 4'h0, 0, 0, 4'h0, 0, 0);
        add("en_off1",  1, 4'h1, 4'h1, 1, 0, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0, 0);
        add("en_on",    1, 4'h1, 4'h1, 1, 1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0, 0);
        add("en_xfer",  1, 4'h1, 4'h1, 1, 1, 4'hF, 0, 4'h1, 1, 1, 4'h1, 0, 1);
        // synchronous reset in the middle of a 4-beat packet on port 2
        add("rst_idle",  1, 4'h4, 4'h0, 1, 1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0, 0);
        add("rst_beat0", 1, 4'h4, 4'h0, 1, 1, 4'hF, 0, 4'h4, 1, 0, 4'h4, 0, 1);
        add("rst_beat1", 1, 4'h4, 4'h0, 1, 1, 4'hF, 0, 4'h4, 1, 0, 4'h4, 0, 1);
        add("rst_low",   0, 4'h4, 4'h0, 1, 1, 4'hF, 0, 4'h4, 1, 0, 4'h4, 0, 1);
        add("rst_after", 1, 4'h5, 4'h0, 1, 1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0, 0);
        add("rst_p0",    1, 4'h5, 4'h1, 1, 1, 4'hF, 0, 4'h1, 1, 1, 4'h1, 0, 1);
        add("rst_end",   1, 4'h0, 4'h0, 1, 1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0, 0);
    endtask

    initial begin
        vec_t          v;
        logic [1:0]    exp_state;
        logic [DW-1:0] exp_data;

        reset_    = 1'b0;
        s_tvalid  = '0;
        s_tlast   = '0;
        s_tdata   = '0;
        m_tready  = 1'b0;
        enable    = 1'b0;
        port_mask = '0;
        gap       = '0;
        build_table();
        repeat (2) @(posedge clk);

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            @(negedge clk);
            reset_    = v.rst_n;
            s_tvalid  = v.sv;
            s_tlast   = v.sl;
            m_tready  = v.tr;
            enable    = v.en;
            port_mask = v.mask;
            gap       = v.gp;
            for (int i = 0; i < NP; i++)
                s_tdata[i*DW +: DW] = {32'(k), 32'(i)};
            if (v.emv && v.tr)
                exp_q.push_back({32'(k), 32'(onehot_idx(v.eg))});
            #1;
            exp_state = v.eb ? 2'd1 : (v.ega ? 2'd2 : 2'd0);
            chk({v.name, "_grant"},    k, DW'(grant),      DW'(v.eg));
            chk({v.name, "_m_tvalid"}, k, DW'(m_tvalid),   DW'(v.emv));
            chk({v.name, "_m_tlast"},  k, DW'(m_tlast),    DW'(v.eml));
            chk({v.name, "_s_tready"}, k, DW'(s_tready),   DW'(v.esr));
            chk({v.name, "_gap_act"},  k, DW'(gap_active), DW'(v.ega));
            chk({v.name, "_busy"},     k, DW'(busy),       DW'(v.eb));
            chk({v.name, "_state"},    k, DW'(state_dbg),  DW'(exp_state));
            chk({v.name, "_grant_oh"}, k, DW'($onehot0(grant)),    DW'(1));
            chk({v.name, "_ready_oh"}, k, DW'($onehot0(s_tready)), DW'(1));
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk({v.name, "_sb_extra_beat"}, k, DW'(1), DW'(0));
                end else begin
                    exp_data = exp_q.pop_front();
                    chk({v.name, "_data"}, k, m_tdata, exp_data);
                end
            end
        end

        @(negedge clk);
        chk("sb_leftover", -1, DW'(exp_q.size()), DW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
